arrow_input_tracker: RTL and testbench
======================================

Name: arrow_input_tracker

Overview:
- Consumes the keyboard decoder's scan-code/press outputs and tracks the four StepMania arrow directions.
- Produces a per-direction held mask and one-cycle hit/release pulses.
- Queues timestamped hit events in a small FIFO for the downstream judgement logic.
- Sits directly downstream of the keyboard instance in the top level, in the same clock domain.

Parameters:
- CODE_LEFT, 8'h6B, scan code mapped to direction 0 (left)
- CODE_DOWN, 8'h72, scan code mapped to direction 1 (down)
- CODE_UP, 8'h75, scan code mapped to direction 2 (up)
- CODE_RIGHT, 8'h74, scan code mapped to direction 3 (right)
- TS_W, 16, timestamp counter width
- DEPTH, 8, event FIFO depth in entries (power of two, >=2)
- HOLD_MAX, 16'd5000, auto-release limit in tick periods (used only with the optional feature)

Ports:
- Clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-low reset
- keyCode  in  8  current scan code from the keyboard decoder
- press  in  1  1 = make, 0 = break, for keyCode
- tick  in  1  one-cycle timebase strobe that advances the timestamp
- held  out  4  per-direction held state
- hit  out  4  one-cycle pulse on a new make per direction
- release  out  4  one-cycle pulse on a break per direction
- evt_valid  out  1  FIFO non-empty
- evt_dir  out  2  head entry direction
- evt_ts  out  TS_W  head entry timestamp
- evt_ready  in  1  consumer pops the head when evt_valid & evt_ready
- overflow  out  1  sticky flag: a push was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (reset=0, async):
  - held, hit, release, evt_valid, overflow, timestamp, FIFO pointers and count all 0.
  - Previous-input register = {press=0, keyCode=8'h00}.
  - The effect is immediate and applies mid-operation; all queued events are discarded.
- Input stage:
  - {press, keyCode} registered once (stage 1).
  - An event is detected when stage-1 value != previous-input register; that register then updates.
  - Unchanged input (including typematic repeats) produces no event.
- Decode: the stage-1 keyCode is compared against the four CODE_* parameters. Unmapped codes update the previous-input register only; no outputs change.
- Make on direction d:
  - If held[d]=0: held[d]<=1, hit[d] pulses for one cycle, and {d, ts} is pushed to the FIFO.
  - If held[d]=1: ignored.
- Break on direction d:
  - If held[d]=1: held[d]<=0 and release[d] pulses for one cycle.
  - If held[d]=0: ignored.
- Latency:
  - held, hit and release change on the 2nd rising edge after the new input is present.
  - The FIFO entry is visible at the head (evt_valid=1) one edge after hit.
- Event rate: at most one event per cycle, so hit and release are at most one-hot.
- Timestamp: ts increments by 1 on each cycle with tick=1 and wraps modulo 2^TS_W (16'hFFFF -> 16'h0000). A pushed entry captures ts as it stands in the detection cycle.
- FIFO:
  - Synchronous, registered count, no fall-through. evt_dir and evt_ts always show the head entry.
  - Pop when empty is ignored.
  - Push when full with no pop: entry dropped, overflow <= 1.
  - Push and pop together when full: both occur and count stays DEPTH.
  - Push and pop together when 0 < count < DEPTH: count unchanged.
  - Pointers wrap modulo DEPTH.
- overflow: cleared by clr_ovf=1. If a drop and clr_ovf coincide, the drop wins and overflow stays 1.

Optional Feature:
- Macro: ARROW_HOLD_TIMEOUT_EN.
- Defined:
  - Each direction has a hold counter that is cleared on make and increments on tick while held.
  - On reaching HOLD_MAX, held[d] <= 0 and release[d] pulses, as if a break arrived (recovers from a lost PS/2 break code).
  - A later real break for that direction is ignored.
  - If a timeout and a real event coincide, the real event has priority and the timeout applies the next cycle.
- Undefined: no counters are built, and held clears only on a break.

Test Plan:
- Reset, then keyCode=8'h75, press=1 -> hit=4'b0100 for one cycle 2 edges later; held=4'b0100; evt_valid=1 next edge, evt_dir=2, evt_ts=current ts.
- Hold up, set keyCode=8'h75, press=0 -> release=4'b0100 pulse, held=0, no FIFO push. Repeat press=1 twice with no change in between -> exactly one hit.
- keyCode=8'h1C (unmapped), press=1 -> held, hit and release stay 0; evt_valid stays 0.
- evt_ready=0, 9 alternating make/break pairs on left -> 8 entries queued, 9th dropped, overflow=1. Pop all 8 -> dir=0 each, timestamps nondecreasing. Pulse clr_ovf -> overflow=0.
- FIFO full, make on right with evt_ready=1 in the same cycle -> count stays 8 and overflow stays 0.
- Preload ts=16'hFFFF, tick=1 -> ts=0; a make in that cycle logs 16'hFFFF. With ARROW_HOLD_TIMEOUT_EN and HOLD_MAX=3, hold down for 3 ticks -> release=4'b0010 pulse and held=0. Assert reset mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/arrow_input_tracker.sv
// arrow_input_tracker
// Turns the keyboard decoder's {press, keyCode} stream into StepMania arrow
// state. It provides a per-direction held mask, one-cycle hit and release
// pulses, and a small FIFO of timestamped hit events for the judgement logic.
//
// The release pulses are on the port 'released' because 'release' is a
// reserved word in SystemVerilog.
//
// Optional build: define ARROW_HOLD_TIMEOUT_EN to add a per-direction hold
// timeout of HOLD_MAX tick periods. The timeout releases a direction whose
// break code was lost on the PS/2 link.
module arrow_input_tracker #(
    parameter logic [7:0] CODE_LEFT  = 8'h6B,
    parameter logic [7:0] CODE_DOWN  = 8'h72,
    parameter logic [7:0] CODE_UP    = 8'h75,
    parameter logic [7:0] CODE_RIGHT = 8'h74,
    parameter int         TS_W       = 16,
    parameter int         DEPTH      = 8
`ifdef ARROW_HOLD_TIMEOUT_EN
    ,
    parameter logic [15:0] HOLD_MAX  = 16'd5000
`endif
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic [7:0]      keyCode,
    input  logic            press,
    input  logic            tick,
    output logic [3:0]      held,
    output logic [3:0]      hit,
    output logic [3:0]      released,
    output logic            evt_valid,
    output logic [1:0]      evt_dir,
    output logic [TS_W-1:0] evt_ts,
    input  logic            evt_ready,
    output logic            overflow,
    input  logic            clr_ovf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam int ENTRY_W = TS_W + 2;

    // Stage-1 copy of the decoder outputs and the last input value acted upon
    logic [7:0]      s1_code;
    logic            s1_press;
    logic [7:0]      prev_code;
    logic            prev_press;

    // Free-running timestamp advanced by the tick strobe
    logic [TS_W-1:0] ts;

    // Decode and event qualification
    logic            in_changed;
    logic [3:0]      dir_match;
    logic            dir_mapped;
    logic [1:0]      dir_idx;
    logic            make_new;
    logic            break_held;

    // Next values of the registered outputs
    logic [3:0]      held_next;
    logic [3:0]      hit_next;
    logic [3:0]      rel_next;
    logic            push_next;

    // Registered push request, written into the FIFO one cycle after hit
    logic            push_req;
    logic [1:0]      push_dir;
    logic [TS_W-1:0] push_ts;

    // Event FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_pop;
    logic               do_push;
    logic               drop;

`ifdef ARROW_HOLD_TIMEOUT_EN
    // Hold-timeout counters, one per direction
    logic [15:0]     hold_cnt [4];
    logic [3:0]      timeout_due;
    logic            timeout_any;
    logic [1:0]      timeout_dir;
`endif

    // Register the decoder outputs once, and remember the last value seen so
    // typematic repeats of the same code produce no event
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            s1_code    <= 8'h00;
            s1_press   <= 1'b0;
            prev_code  <= 8'h00;
            prev_press <= 1'b0;
        end else begin
            s1_code  <= keyCode;
            s1_press <= press;
            if (in_changed) begin
                prev_code  <= s1_code;
                prev_press <= s1_press;
            end
        end
    end

    // Timestamp advances on each tick and wraps naturally at 2^TS_W
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else if (tick) begin
            ts <= ts + TS_W'(1);
        end
    end

    // Detect a change of input and map the stage-1 scan code to a direction
    always_comb begin
        in_changed = ({s1_press, s1_code} != {prev_press, prev_code});
        dir_match  = 4'b0000;
        dir_idx    = 2'd0;
        if (s1_code == CODE_LEFT) begin
            dir_match[0] = 1'b1;
        end
        if (s1_code == CODE_DOWN) begin
            dir_match[1] = 1'b1;
        end
        if (s1_code == CODE_UP) begin
            dir_match[2] = 1'b1;
        end
        if (s1_code == CODE_RIGHT) begin
            dir_match[3] = 1'b1;
        end
        dir_mapped = |dir_match;
        if (dir_match[0]) begin
            dir_idx = 2'd0;
        end else if (dir_match[1]) begin
            dir_idx = 2'd1;
        end else if (dir_match[2]) begin
            dir_idx = 2'd2;
        end else if (dir_match[3]) begin
            dir_idx = 2'd3;
        end
    end

`ifdef ARROW_HOLD_TIMEOUT_EN
    // Find directions held for HOLD_MAX ticks; the lowest index is served first
    always_comb begin
        timeout_due = 4'b0000;
        timeout_any = 1'b0;
        timeout_dir = 2'd0;
        for (int d = 0; d < 4; d++) begin
            timeout_due[d] = held[d] && (hold_cnt[d] >= HOLD_MAX);
        end
        for (int d = 3; d >= 0; d--) begin
            if (timeout_due[d]) begin
                timeout_any = 1'b1;
                timeout_dir = 2'(d);
            end
        end
    end

    // Hold counters restart on a make and count ticks while the key is held
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 4; d++) begin
                hold_cnt[d] <= 16'd0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (make_new && (dir_idx == 2'(d))) begin
                    hold_cnt[d] <= 16'd0;
                end else if (held[d] && tick && (hold_cnt[d] < HOLD_MAX)) begin
                    hold_cnt[d] <= hold_cnt[d] + 16'd1;
                end
            end
        end
    end
`endif

    // Apply the make/break rules; a real key event outranks a pending timeout,
    // which simply waits for the next free cycle
    always_comb begin
        make_new   = 1'b0;
        break_held = 1'b0;
        held_next  = held;
        hit_next   = 4'b0000;
        rel_next   = 4'b0000;
        push_next  = 1'b0;
        if (in_changed && dir_mapped) begin
            if (s1_press && !held[dir_idx]) begin
                make_new = 1'b1;
            end else if (!s1_press && held[dir_idx]) begin
                break_held = 1'b1;
            end
        end
        if (make_new) begin
            held_next[dir_idx] = 1'b1;
            hit_next[dir_idx]  = 1'b1;
            push_next          = 1'b1;
        end else if (break_held) begin
            held_next[dir_idx] = 1'b0;
            rel_next[dir_idx]  = 1'b1;
        end
`ifdef ARROW_HOLD_TIMEOUT_EN
        else if (timeout_any) begin
            held_next[timeout_dir] = 1'b0;
            rel_next[timeout_dir]  = 1'b1;
        end
`endif
    end

    // Register held state and the one-cycle hit/release pulses
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            held     <= 4'b0000;
            hit      <= 4'b0000;
            released <= 4'b0000;
        end else begin
            held     <= held_next;
            hit      <= hit_next;
            released <= rel_next;
        end
    end

    // Capture the direction and detection-cycle timestamp of each new hit
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            push_req <= 1'b0;
            push_dir <= 2'd0;
            push_ts  <= '0;
        end else begin
            push_req <= push_next;
            if (push_next) begin
                push_dir <= dir_idx;
                push_ts  <= ts;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a
    // push when the consumer is reading
    always_comb begin
        do_pop  = evt_ready && (count != '0);
        drop    = push_req && (count == FULL_CNT) && !do_pop;
        do_push = push_req && !drop;
    end

    // FIFO storage, pointers and registered occupancy count
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= {push_dir, push_ts};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_dir   = fifo_mem[rd_ptr][ENTRY_W-1:TS_W];
    assign evt_ts    = fifo_mem[rd_ptr][TS_W-1:0];

endmodule

// File: tb/tb_arrow_input_tracker.sv
// tb_arrow_input_tracker
// Directed and randomized stimulus for arrow_input_tracker. Every cycle is
// compared against a behavioural model built from the make/break rules, a
// queue for the event FIFO, and a plain counter for the timestamp.
module tb_arrow_input_tracker;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;

    logic            Clk;
    logic            reset;
    logic [7:0]      keyCode;
    logic            press;
    logic            tick;
    logic [3:0]      held;
    logic [3:0]      hit;
    logic [3:0]      released;
    logic            evt_valid;
    logic [1:0]      evt_dir;
    logic [TS_W-1:0] evt_ts;
    logic            evt_ready;
    logic            overflow;
    logic            clr_ovf;

    int vectors;
    int miscompares;
    bit checkEnable;

    // Reference model state
    logic [3:0]        held_m;
    logic [3:0]        hit_m;
    logic [3:0]        rel_m;
    logic              ovf_m;
    logic [TS_W-1:0]   ts_m;
    logic [8:0]        stage_m;
    logic [8:0]        prev_m;
    bit                pend_v;
    logic [TS_W+1:0]   pend_e;
    logic [TS_W+1:0]   fifo_m [$];

    arrow_input_tracker dut (
        .Clk       (Clk),
        .reset     (reset),
        .keyCode   (keyCode),
        .press     (press),
        .tick      (tick),
        .held      (held),
        .hit       (hit),
        .released  (released),
        .evt_valid (evt_valid),
        .evt_dir   (evt_dir),
        .evt_ts    (evt_ts),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // 100 MHz free-running clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int dirOf(input logic [7:0] code);
        case (code)
            8'h6B:   return 0;
            8'h72:   return 1;
            8'h75:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        held_m  = 4'b0000;
        hit_m   = 4'b0000;
        rel_m   = 4'b0000;
        ovf_m   = 1'b0;
        ts_m    = '0;
        stage_m = 9'h000;
        prev_m  = 9'h000;
        pend_v  = 1'b0;
        pend_e  = '0;
        fifo_m.delete();
    endtask

    // One rising edge of behaviour: FIFO traffic, then event rules, then time
    task automatic modelEdge(input logic [7:0] code, input logic pr, input logic tk,
                             input logic rdy, input logic clr);
        bit dropped;
        int d;
        hit_m   = 4'b0000;
        rel_m   = 4'b0000;
        dropped = 1'b0;
        if (rdy && fifo_m.size() > 0) begin
            void'(fifo_m.pop_front());
        end
        if (pend_v) begin
            if (fifo_m.size() < DEPTH) begin
                fifo_m.push_back(pend_e);
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) begin
            ovf_m = 1'b1;
        end else if (clr) begin
            ovf_m = 1'b0;
        end
        pend_v = 1'b0;
        if (stage_m != prev_m) begin
            prev_m = stage_m;
            d = dirOf(stage_m[7:0]);
            if (d >= 0) begin
                if (stage_m[8] && !held_m[d]) begin
                    held_m[d] = 1'b1;
                    hit_m[d]  = 1'b1;
                    pend_v    = 1'b1;
                    pend_e    = {2'(d), ts_m};
                end else if (!stage_m[8] && held_m[d]) begin
                    held_m[d] = 1'b0;
                    rel_m[d]  = 1'b1;
                end
            end
        end
        if (tk) begin
            ts_m = ts_m + 16'd1;
        end
        stage_m = {pr, code};
    endtask

    task automatic compareAll();
        logic [TS_W+1:0] head;
        checkOutput("held", {28'd0, held}, {28'd0, held_m});
        checkOutput("hit", {28'd0, hit}, {28'd0, hit_m});
        checkOutput("release", {28'd0, released}, {28'd0, rel_m});
        checkOutput("evt_valid", {31'd0, evt_valid}, {31'd0, fifo_m.size() > 0});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        if (fifo_m.size() > 0) begin
            head = fifo_m[0];
            checkOutput("evt_dir", {30'd0, evt_dir}, {30'd0, head[TS_W+1:TS_W]});
            checkOutput("evt_ts", {16'd0, evt_ts}, {16'd0, head[TS_W-1:0]});
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check after it
    task automatic applyStimulus(input logic [7:0] code, input logic pr, input logic tk,
                                 input logic rdy, input logic clr);
        keyCode   = code;
        press     = pr;
        tick      = tk;
        evt_ready = rdy;
        clr_ovf   = clr;
        @(posedge Clk);
        modelEdge(code, pr, tk, rdy, clr);
        #1;
        if (checkEnable) begin
            compareAll();
        end
    endtask

    // Pop until the model FIFO is empty, keeping the key inputs unchanged
    task automatic drainFifo();
        for (int i = 0; i < 20 && fifo_m.size() > 0; i++) begin
            applyStimulus(keyCode, press, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", {31'd0, evt_valid}, 32'd0);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        int hitCount;
        int pops;
        int n;
        logic [TS_W-1:0] lastTs;
        logic [TS_W+1:0] head;
        logic [7:0] rc;
        logic rp;

        vectors     = 0;
        miscompares = 0;
        checkEnable = 1'b1;
        reset       = 1'b0;
        keyCode     = 8'h00;
        press       = 1'b0;
        tick        = 1'b0;
        evt_ready   = 1'b0;
        clr_ovf     = 1'b0;
        resetModel();

        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_held", {28'd0, held}, 32'd0);
        checkOutput("rst_hit", {28'd0, hit}, 32'd0);
        checkOutput("rst_release", {28'd0, released}, 32'd0);
        checkOutput("rst_valid", {31'd0, evt_valid}, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge Clk);
        reset = 1'b1;

        $display("[TB] make on up");
        applyStimulus(8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("up_hit_early", {28'd0, hit}, 32'd0);
        applyStimulus(8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("up_hit", {28'd0, hit}, 32'b0100);
        checkOutput("up_held", {28'd0, held}, 32'b0100);
        checkOutput("up_valid_early", {31'd0, evt_valid}, 32'd0);
        applyStimulus(8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("up_hit_once", {28'd0, hit}, 32'd0);
        checkOutput("up_valid", {31'd0, evt_valid}, 32'd1);
        checkOutput("up_dir", {30'd0, evt_dir}, 32'd2);
        checkOutput("up_ts", {16'd0, evt_ts}, 32'd0);

        $display("[TB] break on up and typematic repeat");
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("up_release", {28'd0, released}, 32'b0100);
        checkOutput("up_held_clr", {28'd0, held}, 32'd0);
        hitCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
            hitCount += $countones(hit);
        end
        checkOutput("repeat_one_hit", hitCount, 32'd1);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        drainFifo();

        $display("[TB] unmapped code");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("unmapped_held", {28'd0, held}, 32'd0);
            checkOutput("unmapped_hit", {28'd0, hit}, 32'd0);
            checkOutput("unmapped_valid", {31'd0, evt_valid}, 32'd0);
        end

        $display("[TB] overflow on left");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0);
            applyStimulus(8'h6B, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
        lastTs = '0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("pop_valid", {31'd0, evt_valid}, 32'd1);
            checkOutput("pop_dir", {30'd0, evt_dir}, 32'd0);
            checkOutput("pop_ts_order", {31'd0, evt_ts >= lastTs}, 32'd1);
            if (fifo_m.size() > 0) begin
                head   = fifo_m[0];
                lastTs = head[TS_W-1:0];
            end
            applyStimulus(8'h6B, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("pop_empty", {31'd0, evt_valid}, 32'd0);
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
        applyStimulus(8'h6B, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

        $display("[TB] push and pop together when full");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0);
            applyStimulus(8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("full_hit_right", {28'd0, hit}, 32'b1000);
        applyStimulus(8'h74, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("full_no_ovf", {31'd0, overflow}, 32'd0);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (!evt_valid) break;
            applyStimulus(8'h74, 1'b1, 1'b0, 1'b1, 1'b0);
            pops++;
        end
        checkOutput("full_pop_count", pops, 32'd8);

        $display("[TB] timestamp wrap");
        applyStimulus(8'h74, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h74, 1'b0, 1'b0, 1'b0, 1'b0);
        checkEnable = 1'b0;
        n = int'(16'hFFFF - ts_m);
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'h74, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkEnable = 1'b1;
        applyStimulus(8'h6B, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h6B, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_valid", {31'd0, evt_valid}, 32'd1);
        checkOutput("wrap_ts_ffff", {16'd0, evt_ts}, 32'h0000FFFF);
        applyStimulus(8'h6B, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_ts_zero", {16'd0, evt_ts}, 32'd0);
        checkOutput("wrap_dir_down", {30'd0, evt_dir}, 32'd1);

        $display("[TB] asynchronous reset while down is held");
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_held", {28'd0, held}, 32'd0);
        checkOutput("midrst_hit", {28'd0, hit}, 32'd0);
        checkOutput("midrst_release", {28'd0, released}, 32'd0);
        checkOutput("midrst_valid", {31'd0, evt_valid}, 32'd0);
        checkOutput("midrst_ovf", {31'd0, overflow}, 32'd0);
        resetModel();
        @(negedge Clk);
        reset = 1'b1;

        $display("[TB] randomized traffic");
        rc = 8'h00;
        rp = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 5))
                    0:       rc = 8'h6B;
                    1:       rc = 8'h72;
                    2:       rc = 8'h75;
                    3:       rc = 8'h74;
                    4:       rc = 8'h1C;
                    default: rc = 8'($urandom);
                endcase
                rp = 1'($urandom_range(0, 1));
            end
            applyStimulus(rc, rp, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
